// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM wrapper port between NUM_REQ requesters.
// Optional per-requester grant counters are enabled with the SRAM_ARB_PERF_CNT_EN macro.
module sram_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 16,
  parameter int RD_LAT  = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ-1:0]          req_wmode,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  input  logic                        quiesce,
  output logic                        quiesced,
  output logic                        sram_en,
  output logic                        sram_wmode,
  output logic [ADDR_W-1:0]           sram_addr,
  output logic [DATA_W-1:0]           sram_wdata,
  input  logic [DATA_W-1:0]           sram_rdata
`ifdef SRAM_ARB_PERF_CNT_EN
  ,
  output logic [NUM_REQ*16-1:0]       grant_cnt
`endif
);

  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t           state;
  logic [IDW-1:0]   ptr;
  logic             grant_any;
  logic [IDW-1:0]   gnt_idx;
  int               cand;
  logic [RD_LAT-1:0] tag_v;
  logic [IDW-1:0]   tag_id [RD_LAT];
  logic             pipe_empty;

  assign pipe_empty = ~|tag_v;

  // Grant the first valid requester at or above the pointer; silent outside RUN.
  always_comb begin
    grant_any = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    if (!rst && state == RUN && !quiesce) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = (int'(ptr) + k) % NUM_REQ;
        if (!grant_any && req_valid[cand]) begin
          grant_any = 1'b1;
          gnt_idx   = IDW'(cand);
        end else begin
          grant_any = grant_any;
        end
      end
    end else begin
      grant_any = 1'b0;
    end
    if (grant_any) begin
      req_ready = NUM_REQ'(1) << gnt_idx;
    end else begin
      req_ready = '0;
    end
  end

  // Registered SRAM drive; address/data/mode hold their last value when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= '0;
      sram_en    <= 1'b0;
      sram_wmode <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else if (grant_any) begin
      ptr        <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + IDW'(1);
      sram_en    <= 1'b1;
      sram_wmode <= req_wmode[gnt_idx];
      sram_addr  <= req_addr[gnt_idx*ADDR_W +: ADDR_W];
      sram_wdata <= req_wdata[gnt_idx*DATA_W +: DATA_W];
    end else begin
      sram_en    <= 1'b0;
    end
  end

  // Read tag pipe: stage 0 lines up with sram_en, the last stage feeds the response strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v     <= '0;
      rsp_valid <= '0;
      for (int s = 0; s < RD_LAT; s++) begin
        tag_id[s] <= '0;
      end
    end else begin
      tag_v[0]  <= grant_any & ~req_wmode[gnt_idx];
      tag_id[0] <= gnt_idx;
      for (int s = 1; s < RD_LAT; s++) begin
        tag_v[s]  <= tag_v[s-1];
        tag_id[s] <= tag_id[s-1];
      end
      rsp_valid <= tag_v[RD_LAT-1] ? (NUM_REQ'(1) << tag_id[RD_LAT-1]) : '0;
    end
  end

  assign rsp_rdata = (|rsp_valid) ? sram_rdata : '0;

  // Quiesce FSM; quiesced mirrors residence in HALT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      quiesced <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          state    <= quiesce ? DRAIN : RUN;
          quiesced <= 1'b0;
        end
        DRAIN: begin
          if (!quiesce) begin
            state    <= RUN;
            quiesced <= 1'b0;
          end else if (pipe_empty && !sram_en) begin
            state    <= HALT;
            quiesced <= 1'b1;
          end else begin
            state    <= DRAIN;
            quiesced <= 1'b0;
          end
        end
        HALT: begin
          state    <= quiesce ? HALT : RUN;
          quiesced <= quiesce;
        end
        default: begin
          state    <= RUN;
          quiesced <= 1'b0;
        end
      endcase
    end
  end

`ifdef SRAM_ARB_PERF_CNT_EN
  // Saturating per-requester transfer counters, frozen while quiesced.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && !quiesced && grant_cnt[i*16 +: 16] != 16'hFFFF) begin
          grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
        end else begin
          grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Self-checking bench for sram_rr_arbiter: directed steps plus random traffic against a
// transaction-level reference model (round-robin rule, memory image, response queue).
module tb_sram_rr_arbiter;
  localparam int N  = 4;
  localparam int AW = 4;
  localparam int DW = 16;
  localparam int RL = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    req_valid, req_ready, req_wmode, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, sram_wdata, sram_rdata;
  logic            quiesce, quiesced, sram_en, sram_wmode;
  logic [AW-1:0]   sram_addr;
`ifdef SRAM_ARB_PERF_CNT_EN
  logic [N*16-1:0] grant_cnt;
`endif

  sram_rr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_wmode(req_wmode), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .quiesce(quiesce), .quiesced(quiesced),
    .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
`ifdef SRAM_ARB_PERF_CNT_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  function automatic logic [DW-1:0] init_val(input int a);
    return 16'h1357 + 16'(a * 16'h0421);
  endfunction

  // SRAM wrapper device: read data appears RL cycles after the enable cycle.
  logic [DW-1:0] dev_mem [16];
  logic [15:0]   dev_written = 16'h0000;
  logic [DW-1:0] rd_pipe [RL];
  assign sram_rdata = rd_pipe[RL-1];
  always @(posedge clk) begin
    if (sram_en === 1'b1 && sram_wmode === 1'b1) begin
      dev_mem[sram_addr]     <= sram_wdata;
      dev_written[sram_addr] <= 1'b1;
    end
    if (sram_en === 1'b1 && sram_wmode === 1'b0)
      rd_pipe[0] <= dev_written[sram_addr] ? dev_mem[sram_addr] : init_val(int'(sram_addr));
    else
      rd_pipe[0] <= 16'h0000;
    for (int s = 1; s < RL; s++) rd_pipe[s] <= rd_pipe[s-1];
  end

  typedef struct {int id; logic [DW-1:0] data; int due;} rsp_t;
  rsp_t          q[$];
  logic [DW-1:0] ref_mem [16];
  int            m_state, m_ptr, cyc, checks, failures;
  bit            m_en, m_wmode;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  int            m_cnt [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs mid-cycle against the model, then advance the model.
  task automatic step(input bit do_chk);
    int g, a;
    bit busy;
    logic [N-1:0]  er, ev;
    logic [DW-1:0] ed;
    @(negedge clk);
    g = -1;
    if (!rst && m_state == 0 && !quiesce)
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (g < 0 && req_valid[c]) g = c;
      end
    er = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    ev = 4'b0000;
    ed = 16'h0000;
    if (q.size() > 0 && q[0].due == cyc) begin
      ev = 4'b0001 << q[0].id;
      ed = q[0].data;
      void'(q.pop_front());
    end
    if (do_chk) begin
      chk("req_ready", req_ready, er);
      chk("rsp_valid", rsp_valid, ev);
      chk("rsp_rdata", rsp_rdata, ed);
      chk("quiesced", quiesced, (m_state == 2));
      chk("sram_en", sram_en, m_en);
      chk("sram_wmode", sram_wmode, m_wmode);
      chk("sram_addr", sram_addr, m_addr);
      chk("sram_wdata", sram_wdata, m_wdata);
`ifdef SRAM_ARB_PERF_CNT_EN
      for (int i = 0; i < N; i++) chk("grant_cnt", grant_cnt[i*16 +: 16], 64'(m_cnt[i]));
`endif
    end
    busy = 1'b0;
    foreach (q[j]) if (q[j].due > cyc && q[j].due - RL <= cyc) busy = 1'b1;
    if (rst) begin
      m_state = 0; m_ptr = 0; q.delete();
      m_en = 0; m_wmode = 0; m_addr = '0; m_wdata = '0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else begin
      case (m_state)
        0: if (quiesce) m_state = 1;
        1: if (!quiesce) m_state = 0; else if (!busy && !m_en) m_state = 2;
        2: if (!quiesce) m_state = 0;
        default: m_state = 0;
      endcase
      m_en = (g >= 0);
      if (g >= 0) begin
        m_ptr   = (g + 1) % N;
        a       = int'(req_addr[g*AW +: AW]);
        m_addr  = req_addr[g*AW +: AW];
        m_wdata = req_wdata[g*DW +: DW];
        m_wmode = req_wmode[g];
        if (m_cnt[g] < 65535) m_cnt[g]++;
        if (req_wmode[g]) ref_mem[a] = req_wdata[g*DW +: DW];
        else q.push_back('{id: g, data: ref_mem[a], due: cyc + 1 + RL});
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit v, input bit w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_valid[i] = v;
    req_wmode[i] = w;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; m_state = 0; m_ptr = 0;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
    for (int s = 0; s < RL; s++) rd_pipe[s] = 16'h0000;
    rst = 1'b1; quiesce = 1'b0;
    req_valid = 4'b1111; req_wmode = 4'b0000; req_addr = '0; req_wdata = '0;
    @(posedge clk); #1;
    // Two reset cycles with every requester valid; outputs must be zero by the second.
    step(1'b0);
    step(1'b1);
    rst = 1'b0;
    // Fairness: all requesters valid for 8 cycles.
    for (int i = 0; i < 8; i++) step(1'b1);
    req_valid = 4'b0000;
    step(1'b1);
    // Write 0xBEEF at 5 from req 2, then read it back from req 1.
    set_req(2, 1'b1, 1'b1, 4'd5, 16'hBEEF);
    step(1'b1);
    req_valid = 4'b0000;
    set_req(1, 1'b1, 1'b0, 4'd5, 16'h0000);
    step(1'b1);
    req_valid = 4'b0000;
    for (int i = 0; i < RL + 2; i++) step(1'b1);
    // Back-to-back reads from req 0 and req 3.
    set_req(0, 1'b1, 1'b0, 4'd3, 16'h0000);
    step(1'b1);
    req_valid = 4'b0000;
    set_req(3, 1'b1, 1'b0, 4'd7, 16'h0000);
    step(1'b1);
    req_valid = 4'b0000;
    for (int i = 0; i < RL + 2; i++) step(1'b1);
    // Quiesce with two reads in flight, then release.
    set_req(0, 1'b1, 1'b0, 4'd1, 16'h0000);
    step(1'b1);
    req_valid = 4'b0000;
    set_req(1, 1'b1, 1'b0, 4'd2, 16'h0000);
    step(1'b1);
    quiesce = 1'b1; req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) step(1'b1);
    chk("quiesced_after_drain", quiesced, 1'b1);
    quiesce = 1'b0;
    step(1'b1);
    step(1'b1);
    // Reset one cycle after a read accept: its response must never appear.
    req_valid = 4'b0000;
    set_req(2, 1'b1, 1'b0, 4'd4, 16'h0000);
    step(1'b1);
    rst = 1'b1; req_valid = 4'b0000;
    step(1'b1);
    rst = 1'b0;
    for (int i = 0; i < RL + 3; i++) step(1'b1);
    // Random traffic with occasional quiesce and reset.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 99) < 4) quiesce = ~quiesce;
      for (int i = 0; i < N; i++)
        set_req(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                AW'($urandom_range(0, 3)), DW'($urandom));
      step(1'b1);
    end
    rst = 1'b0; quiesce = 1'b0; req_valid = 4'b0000;
    for (int i = 0; i < RL + 3; i++) step(1'b1);
    chk("rsp_pending", 64'(q.size()), 64'd0);
`ifdef SRAM_ARB_PERF_CNT_EN
    rst = 1'b1;
    step(1'b1);
    rst = 1'b0;
    set_req(0, 1'b1, 1'b1, 4'd0, 16'h0000);
    for (int n = 0; n < 70000; n++) step(1'b1);
    chk("grant_cnt_sat", grant_cnt[15:0], 16'hFFFF);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
